noc_local_injector: RTL and testbench

Local-side packetizer for one NoC node: accepts a packet command (destination, length, VC) plus a payload word stream from the processing element and emits header, body and tail flits onto the node's two injection channels (VC0/VC1) of the NoC fabric. It is the transmitting end of the fabric's per-node `channel0/channel1_receive_*` ports and holds one packet in flight at a time.

---
 rtl/noc_local_injector_pkg.sv | 62 ++++++
 rtl/noc_local_injector.sv | 223 ++++++++++++++++++++++
 tb/tb_noc_local_injector.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/noc_local_injector_pkg.sv
// ---------------------------------------------------------------------------
// Noc_parameters
// Shared definitions for the NoC local injector:
//   - Noc_Data_Width : flit width of the fabric
//   - inj_state_t    : injector FSM state type
//   - hdr_*_lsb      : header field offsets, derived from coordinate/length widths
//   - hdr_pack       : packs a header flit (MSB down: dst_x, dst_y, src_x, src_y,
//                      len, zero fill)
// ---------------------------------------------------------------------------
package Noc_parameters;

   localparam int Noc_Data_Width = 32;

   typedef enum logic [1:0] {
      INJ_IDLE    = 2'd0,
      INJ_WAIT_VC = 2'd1,
      INJ_HEAD    = 2'd2,
      INJ_BODY    = 2'd3
   } inj_state_t;

   function automatic int hdr_dst_x_lsb(input int coord_w);
      return Noc_Data_Width - coord_w;
   endfunction

   function automatic int hdr_dst_y_lsb(input int coord_w);
      return Noc_Data_Width - 2 * coord_w;
   endfunction

   function automatic int hdr_src_x_lsb(input int coord_w);
      return Noc_Data_Width - 3 * coord_w;
   endfunction

   function automatic int hdr_src_y_lsb(input int coord_w);
      return Noc_Data_Width - 4 * coord_w;
   endfunction

   function automatic int hdr_len_lsb(input int coord_w, input int len_w);
      return Noc_Data_Width - 4 * coord_w - len_w;
   endfunction

   // Fields arrive zero-extended to flit width; masks trim them to field size
   function automatic logic [Noc_Data_Width-1:0] hdr_pack(
      input int                        coord_w,
      input int                        len_w,
      input logic [Noc_Data_Width-1:0] dst_x,
      input logic [Noc_Data_Width-1:0] dst_y,
      input logic [Noc_Data_Width-1:0] src_x,
      input logic [Noc_Data_Width-1:0] src_y,
      input logic [Noc_Data_Width-1:0] len
   );
      logic [Noc_Data_Width-1:0] cmask;
      logic [Noc_Data_Width-1:0] lmask;
      cmask = {Noc_Data_Width{1'b1}} >> (Noc_Data_Width - coord_w);
      lmask = {Noc_Data_Width{1'b1}} >> (Noc_Data_Width - len_w);
      return ((dst_x & cmask) << hdr_dst_x_lsb(coord_w))
           | ((dst_y & cmask) << hdr_dst_y_lsb(coord_w))
           | ((src_x & cmask) << hdr_src_x_lsb(coord_w))
           | ((src_y & cmask) << hdr_src_y_lsb(coord_w))
           | ((len   & lmask) << hdr_len_lsb(coord_w, len_w));
   endfunction

endpackage

// File: rtl/noc_local_injector.sv
// ---------------------------------------------------------------------------
// noc_local_injector
// Local-side packetizer: takes a packet command plus a payload word stream and
// emits header/body/tail flits on one of two injection VCs. One packet in
// flight at a time.
//
// Optional feature macro: NOC_INJ_AUTO_VC_EN
//   defined   : pkt_vc ignored; VC0 picked if ch0_vc_ready, else VC1
//   undefined : pkt_vc used strictly
//
// Ports:
//   noc_clk, noc_rst_n         clock, async active-low reset
//   pkt_valid/pkt_ready        command handshake
//   pkt_dst_x/y, pkt_len, pkt_vc  command fields
//   pl_valid/pl_ready/pl_data  payload word stream
//   chN_valid/ready/flit       flit handshake on VC N (N=0,1)
//   chN_vc_ready               VC N can take a new header
//   chN_is_header/is_tail      flit markers
// ---------------------------------------------------------------------------
module noc_local_injector
   import Noc_parameters::*;
#(
   parameter int SRC_X   = 0,
   parameter int SRC_Y   = 0,
   parameter int COORD_W = 1,
   parameter int LEN_W   = 8
) (
   input  logic                      noc_clk,
   input  logic                      noc_rst_n,
   input  logic                      pkt_valid,
   output logic                      pkt_ready,
   input  logic [COORD_W-1:0]        pkt_dst_x,
   input  logic [COORD_W-1:0]        pkt_dst_y,
   input  logic [LEN_W-1:0]          pkt_len,
   input  logic                      pkt_vc,
   input  logic                      pl_valid,
   output logic                      pl_ready,
   input  logic [Noc_Data_Width-1:0] pl_data,
   output logic                      ch0_valid,
   input  logic                      ch0_ready,
   output logic [Noc_Data_Width-1:0] ch0_flit,
   input  logic                      ch0_vc_ready,
   output logic                      ch0_is_header,
   output logic                      ch0_is_tail,
   output logic                      ch1_valid,
   input  logic                      ch1_ready,
   output logic [Noc_Data_Width-1:0] ch1_flit,
   input  logic                      ch1_vc_ready,
   output logic                      ch1_is_header,
   output logic                      ch1_is_tail
);

   localparam int W = Noc_Data_Width;

   inj_state_t           state_r;
   inj_state_t           state_nxt;
   logic                 vc_r;
   logic [COORD_W-1:0]   dst_x_r;
   logic [COORD_W-1:0]   dst_y_r;
   logic [LEN_W-1:0]     len_r;
   logic [LEN_W-1:0]     cnt_r;
   logic                 out_valid_r;
   logic                 out_head_r;
   logic                 out_tail_r;
   logic [W-1:0]         out_flit_r;
   logic                 pkt_ready_r;

   logic                 sel_ready;
   logic                 vc_go;
   logic                 vc_pick;
   logic                 out_fire;
   logic                 pl_fire;
   logic                 cmd_fire;
   logic [W-1:0]         hdr_flit;

   // Handshake qualifiers and VC choice for the current packet
   always_comb begin
      sel_ready = vc_r ? ch1_ready : ch0_ready;
`ifdef NOC_INJ_AUTO_VC_EN
      vc_go     = ch0_vc_ready | ch1_vc_ready;
      vc_pick   = ~ch0_vc_ready;
`else
      vc_go     = vc_r ? ch1_vc_ready : ch0_vc_ready;
      vc_pick   = vc_r;
`endif
      out_fire  = out_valid_r & sel_ready;
      cmd_fire  = pkt_valid & pkt_ready_r;
      hdr_flit  = hdr_pack(COORD_W, LEN_W, W'(dst_x_r), W'(dst_y_r),
                           W'(SRC_X), W'(SRC_Y), W'(len_r));
   end

   // Payload acceptance. The first word is also taken while the header
   // transfers so the body follows the header without a bubble.
   always_comb begin
      case (state_r)
         INJ_HEAD: pl_ready = out_fire & (len_r != {LEN_W{1'b0}});
         INJ_BODY: pl_ready = (cnt_r != {LEN_W{1'b0}}) & (~out_valid_r | sel_ready);
         default:  pl_ready = 1'b0;
      endcase
      pl_fire = pl_valid & pl_ready;
   end

   // Next-state logic
   always_comb begin
      case (state_r)
         INJ_IDLE: begin
            if (cmd_fire) state_nxt = INJ_WAIT_VC;
            else          state_nxt = INJ_IDLE;
         end
         INJ_WAIT_VC: begin
            if (vc_go) state_nxt = INJ_HEAD;
            else       state_nxt = INJ_WAIT_VC;
         end
         INJ_HEAD: begin
            if (!out_fire)                      state_nxt = INJ_HEAD;
            else if (len_r == {LEN_W{1'b0}})    state_nxt = INJ_IDLE;
            else                                state_nxt = INJ_BODY;
         end
         INJ_BODY: begin
            if (out_fire && out_tail_r) state_nxt = INJ_IDLE;
            else                        state_nxt = INJ_BODY;
         end
         default: state_nxt = INJ_IDLE;
      endcase
   end

   // FSM, command latch, length counter and output register
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state_r     <= INJ_IDLE;
         pkt_ready_r <= 1'b0;
         vc_r        <= 1'b0;
         dst_x_r     <= {COORD_W{1'b0}};
         dst_y_r     <= {COORD_W{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         cnt_r       <= {LEN_W{1'b0}};
         out_valid_r <= 1'b0;
         out_head_r  <= 1'b0;
         out_tail_r  <= 1'b0;
         out_flit_r  <= {W{1'b0}};
      end else begin
         state_r     <= state_nxt;
         // Registered so the command port stays closed while in reset
         pkt_ready_r <= (state_nxt == INJ_IDLE);
         case (state_r)
            INJ_IDLE: begin
               if (cmd_fire) begin
                  dst_x_r <= pkt_dst_x;
                  dst_y_r <= pkt_dst_y;
                  len_r   <= pkt_len;
`ifndef NOC_INJ_AUTO_VC_EN
                  vc_r    <= pkt_vc;
`endif
               end
            end
            INJ_WAIT_VC: begin
               if (vc_go) begin
                  vc_r        <= vc_pick;
                  out_valid_r <= 1'b1;
                  out_head_r  <= 1'b1;
                  out_tail_r  <= (len_r == {LEN_W{1'b0}});
                  out_flit_r  <= hdr_flit;
               end
            end
            INJ_HEAD: begin
               if (out_fire) begin
                  out_head_r <= 1'b0;
                  if (pl_fire) begin
                     out_valid_r <= 1'b1;
                     out_flit_r  <= pl_data;
                     out_tail_r  <= (len_r == LEN_W'(1));
                     cnt_r       <= len_r - LEN_W'(1);
                  end else begin
                     out_valid_r <= 1'b0;
                     out_tail_r  <= 1'b0;
                     cnt_r       <= len_r;
                  end
               end
            end
            INJ_BODY: begin
               if (pl_fire) begin
                  out_valid_r <= 1'b1;
                  out_flit_r  <= pl_data;
                  out_tail_r  <= (cnt_r == LEN_W'(1));
                  cnt_r       <= cnt_r - LEN_W'(1);
               end else if (out_fire) begin
                  out_valid_r <= 1'b0;
                  out_tail_r  <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign pkt_ready = pkt_ready_r;

   // Steer the single output register onto the selected VC; the other is idle
   always_comb begin
      if (vc_r) begin
         ch0_valid     = 1'b0;
         ch0_flit      = {W{1'b0}};
         ch0_is_header = 1'b0;
         ch0_is_tail   = 1'b0;
         ch1_valid     = out_valid_r;
         ch1_flit      = out_flit_r;
         ch1_is_header = out_head_r;
         ch1_is_tail   = out_tail_r;
      end else begin
         ch0_valid     = out_valid_r;
         ch0_flit      = out_flit_r;
         ch0_is_header = out_head_r;
         ch0_is_tail   = out_tail_r;
         ch1_valid     = 1'b0;
         ch1_flit      = {W{1'b0}};
         ch1_is_header = 1'b0;
         ch1_is_tail   = 1'b0;
      end
   end

endmodule

// File: tb/tb_noc_local_injector.sv
// ---------------------------------------------------------------------------
// tb_noc_local_injector
// Directed bench for noc_local_injector (default parameters: 32-bit flits,
// 1-bit coordinates, 8-bit length, source (0,0)). Header model:
// {dst_x, dst_y, src_x, src_y, len[7:0], 20'b0}; payload word k = 0xA + k.
// ---------------------------------------------------------------------------
module tb_noc_local_injector;

   logic        noc_clk;
   logic        noc_rst_n;
   logic        pkt_valid;
   logic        pkt_ready;
   logic        pkt_dst_x;
   logic        pkt_dst_y;
   logic [7:0]  pkt_len;
   logic        pkt_vc;
   logic        pl_valid;
   logic        pl_ready;
   logic [31:0] pl_data;
   logic        ch0_valid, ch0_ready, ch0_vc_ready, ch0_is_header, ch0_is_tail;
   logic [31:0] ch0_flit;
   logic        ch1_valid, ch1_ready, ch1_vc_ready, ch1_is_header, ch1_is_tail;
   logic [31:0] ch1_flit;

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc_out;

   noc_local_injector dut (
      .noc_clk       (noc_clk),
      .noc_rst_n     (noc_rst_n),
      .pkt_valid     (pkt_valid),
      .pkt_ready     (pkt_ready),
      .pkt_dst_x     (pkt_dst_x),
      .pkt_dst_y     (pkt_dst_y),
      .pkt_len       (pkt_len),
      .pkt_vc        (pkt_vc),
      .pl_valid      (pl_valid),
      .pl_ready      (pl_ready),
      .pl_data       (pl_data),
      .ch0_valid     (ch0_valid),
      .ch0_ready     (ch0_ready),
      .ch0_flit      (ch0_flit),
      .ch0_vc_ready  (ch0_vc_ready),
      .ch0_is_header (ch0_is_header),
      .ch0_is_tail   (ch0_is_tail),
      .ch1_valid     (ch1_valid),
      .ch1_ready     (ch1_ready),
      .ch1_flit      (ch1_flit),
      .ch1_vc_ready  (ch1_vc_ready),
      .ch1_is_header (ch1_is_header),
      .ch1_is_tail   (ch1_is_tail)
   );

   initial noc_clk = 1'b0;
   always #5 noc_clk = ~noc_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total = checks_total + 1;
      if (got === exp) checks_passed = checks_passed + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge noc_clk);
      #1;
   endtask

   // Send one packet and follow it flit by flit. ovc is the channel the
   // packet is expected on; pat gives ready per cycle from the header cycle.
   task automatic send_packet(input logic dx, input logic dy, input logic [7:0] len,
                              input logic pvc, input logic ovc, input logic [15:0] pat,
                              output int cycles);
      logic [31:0] hdr, exp_flit, f;
      logic        rdy, v, h, t, ov;
      int          idx, pidx, cyc;
      hdr = {dx, dy, 1'b0, 1'b0, len, 20'h0};
      pkt_valid = 1'b1; pkt_dst_x = dx; pkt_dst_y = dy; pkt_len = len; pkt_vc = pvc;
      #2;
      check("cmd_ready", {31'd0, pkt_ready}, 32'd1);
      step();
      pkt_valid = 1'b0;
      #2;
      check("wait_no_valid", {31'd0, ch0_valid | ch1_valid}, 32'd0);
      step();
      idx = 0; pidx = 0; cyc = 0;
      while (idx <= int'(len) && cyc < 40) begin
         rdy = (cyc < 16) ? pat[cyc] : 1'b1;
         ch0_ready = rdy; ch1_ready = rdy;
         pl_valid = 1'b1; pl_data = 32'hA + 32'(pidx);
         #2;
         v  = ovc ? ch1_valid     : ch0_valid;
         f  = ovc ? ch1_flit      : ch0_flit;
         h  = ovc ? ch1_is_header : ch0_is_header;
         t  = ovc ? ch1_is_tail   : ch0_is_tail;
         ov = ovc ? ch0_valid     : ch1_valid;
         exp_flit = (idx == 0) ? hdr : 32'hA + 32'(idx - 1);
         check("flit_valid", {31'd0, v}, 32'd1);
         check("flit_data", f, exp_flit);
         check("flit_header", {31'd0, h}, {31'd0, idx == 0});
         check("flit_tail", {31'd0, t}, {31'd0, idx == int'(len)});
         check("other_vc_idle", {31'd0, ov}, 32'd0);
         check("pl_ready", {31'd0, pl_ready}, {31'd0, rdy && (pidx < int'(len))});
         if (pl_valid && pl_ready) pidx = pidx + 1;
         if (rdy) idx = idx + 1;
         cyc = cyc + 1;
         step();
      end
      check("pkt_done", 32'(idx), 32'(len) + 32'd1);
      pl_valid = 1'b0; ch0_ready = 1'b1; ch1_ready = 1'b1;
      #2;
      check("post_pkt_ready", {31'd0, pkt_ready}, 32'd1);
      check("post_no_valid", {31'd0, ch0_valid | ch1_valid}, 32'd0);
      cycles = cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      noc_rst_n = 1'b0;
      pkt_valid = 1'b0; pkt_dst_x = 1'b0; pkt_dst_y = 1'b0; pkt_len = 8'd0; pkt_vc = 1'b0;
      pl_valid = 1'b0; pl_data = 32'd0;
      ch0_ready = 1'b1; ch1_ready = 1'b1; ch0_vc_ready = 1'b1; ch1_vc_ready = 1'b1;

      // Reset state
      step(); step();
      check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd0);
      check("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
      check("rst_valids", {30'd0, ch0_valid, ch1_valid}, 32'd0);
      check("rst_flags", {28'd0, ch0_is_header, ch0_is_tail, ch1_is_header, ch1_is_tail}, 32'd0);
      check("rst_flit0", ch0_flit, 32'd0);
      check("rst_flit1", ch1_flit, 32'd0);
      noc_rst_n = 1'b1;
      step();
      check("post_rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);

      // Header-only packet dst=(1,0), len=0, vc=0
      pkt_valid = 1'b1; pkt_dst_x = 1'b1; pkt_dst_y = 1'b0; pkt_len = 8'd0; pkt_vc = 1'b0;
      #2;
      check("t1_cmd_ready", {31'd0, pkt_ready}, 32'd1);
      step();
      pkt_valid = 1'b0;
      #2;
      check("t1_T1_no_valid", {31'd0, ch0_valid}, 32'd0);
      step();
      #2;
      check("t1_T2_valid", {31'd0, ch0_valid}, 32'd1);
      check("t1_flit", ch0_flit, 32'h8000_0000);
      check("t1_head_tail", {30'd0, ch0_is_header, ch0_is_tail}, 32'd3);
      check("t1_ch1_idle", {31'd0, ch1_valid}, 32'd0);
      step();
      #2;
      check("t1_done_valid", {31'd0, ch0_valid}, 32'd0);
      check("t1_ready_again", {31'd0, pkt_ready}, 32'd1);
      step();

      // Payload packet len=3 on vc1, ready held high: four back-to-back flits
      send_packet(1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 16'hFFFF, cyc_out);
      check("t2_cycles", 32'(cyc_out), 32'd4);
      step();

      // Backpressure: ready 1,0,0,1,... during a len=4 packet on vc0
      send_packet(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 16'b1111_1111_1111_1001, cyc_out);
      check("t3_cycles", 32'(cyc_out), 32'd7);
      step();

      // VC wait: ch0_vc_ready low for 5 cycles
      ch0_vc_ready = 1'b0;
      pkt_valid = 1'b1; pkt_dst_x = 1'b1; pkt_dst_y = 1'b0; pkt_len = 8'd0; pkt_vc = 1'b0;
      #2;
      check("t4_cmd_ready", {31'd0, pkt_ready}, 32'd1);
      step();
      pkt_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #2;
         check("t4_wait_no_valid", {30'd0, ch0_valid, ch1_valid}, 32'd0);
         step();
      end
      ch0_vc_ready = 1'b1;
      #2;
      check("t4_rise_no_valid", {31'd0, ch0_valid}, 32'd0);
      step();
      #2;
      check("t4_header_valid", {31'd0, ch0_valid}, 32'd1);
      check("t4_header_flit", ch0_flit, 32'h8000_0000);
      step();
      step();

`ifdef NOC_INJ_AUTO_VC_EN
      // Auto VC: only VC1 ready -> ch1 even though pkt_vc=0
      ch0_vc_ready = 1'b0; ch1_vc_ready = 1'b1;
      send_packet(1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 16'hFFFF, cyc_out);
      step();
      // Both ready -> ch0 even though pkt_vc=1
      ch0_vc_ready = 1'b1; ch1_vc_ready = 1'b1;
      send_packet(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 16'hFFFF, cyc_out);
      step();
`endif

      // Reset mid-packet: len=5 on vc0, reset after header + first body flit
      pkt_valid = 1'b1; pkt_dst_x = 1'b0; pkt_dst_y = 1'b0; pkt_len = 8'd5; pkt_vc = 1'b0;
      step();
      pkt_valid = 1'b0;
      step();
      pl_valid = 1'b1; pl_data = 32'hA;
      #2;
      check("t6_header", ch0_flit, 32'h0050_0000);
      step();
      pl_data = 32'hB;
      #2;
      check("t6_body0", ch0_flit, 32'hA);
      step();
      #2;
      check("t6_body1_valid", {31'd0, ch0_valid}, 32'd1);
      noc_rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {30'd0, ch0_valid, ch1_valid}, 32'd0);
      check("t6_rst_flit", ch0_flit, 32'd0);
      check("t6_rst_flags", {30'd0, ch0_is_header, ch0_is_tail}, 32'd0);
      check("t6_rst_readies", {30'd0, pkt_ready, pl_ready}, 32'd0);
      pl_valid = 1'b0;
      step(); step();
      noc_rst_n = 1'b1;
      step();
      send_packet(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 16'hFFFF, cyc_out);
      check("t6_post_cycles", 32'(cyc_out), 32'd4);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
